// File: rtl/mig_burst_engine.sv
// Burst sequencer for the MIG UI port: one start moves len beats to/from consecutive
// addresses, with write-data backpressure and a bounded outstanding-read window.
module mig_burst_engine #(
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 256,
  parameter int ADDR_STEP = 8,
  parameter int LEN_W     = 8,
  parameter int MAX_OUT   = 16
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic                op,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic                app_rd_data_valid,
  input  logic [DATA_W-1:0]   app_rd_data
);

  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [LEN_W-1:0]  issued_reg, issued_next;
  logic [LEN_W-1:0]  returned_reg, returned_next;
  logic [OUT_W-1:0]  outstanding_reg, outstanding_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              rd_last_reg, rd_last_next;
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic [LEN_W-1:0]  len_m1;
  logic              wr_fire, rd_fire, rd_ret;

  assign len_m1 = len_reg - LEN_W'(1);

  always_comb begin
    state_next       = state_reg;
    cur_addr_next    = cur_addr_reg;
    len_next         = len_reg;
    remaining_next   = remaining_reg;
    issued_next      = issued_reg;
    returned_next    = returned_reg;
    outstanding_next = outstanding_reg;
    app_cmd          = 3'b000;
    app_en           = 1'b0;
    wr_fire          = 1'b0;
    rd_fire          = 1'b0;

    // Read returns are only meaningful while a read burst is in flight.
    rd_ret        = app_rd_data_valid && (state_reg == S_RD || state_reg == S_DRAIN);
    rd_valid_next = rd_ret;
    rd_last_next  = rd_ret && (returned_reg == len_m1);
    rd_data_next  = rd_ret ? app_rd_data : rd_data_reg;
    if (rd_ret) returned_next = returned_reg + LEN_W'(1);

    case (state_reg)
      S_IDLE: begin
        if (start && init_calib_complete) begin
          len_next         = len;
          remaining_next   = len;
          cur_addr_next    = base_addr;
          issued_next      = '0;
          returned_next    = '0;
          outstanding_next = '0;
          if (len == '0)  state_next = S_DONE;
          else if (op)    state_next = S_RD;
          else            state_next = S_WR;
        end
      end
      S_WR: begin
        app_en  = wr_valid && app_wdf_rdy;
        wr_fire = wr_valid && app_rdy && app_wdf_rdy;
        if (wr_fire) begin
          cur_addr_next  = cur_addr_reg + ADDR_W'(ADDR_STEP);
          remaining_next = remaining_reg - LEN_W'(1);
          if (remaining_reg == LEN_W'(1)) state_next = S_DONE;
        end
      end
      S_RD: begin
        app_cmd = 3'b001;
        app_en  = (issued_reg < len_reg) && (outstanding_reg < MAX_OUT_C);
        rd_fire = app_en && app_rdy;
        if (rd_fire) begin
          cur_addr_next = cur_addr_reg + ADDR_W'(ADDR_STEP);
          issued_next   = issued_reg + LEN_W'(1);
          if (issued_reg == len_m1) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        app_cmd = 3'b001;
        if (returned_reg == len_reg) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Simultaneous issue and return leave the window count unchanged.
    case ({rd_fire, rd_ret})
      2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
      2'b01:   outstanding_next = (outstanding_reg != '0) ? outstanding_reg - OUT_W'(1) : '0;
      default: ;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_reg       <= S_IDLE;
      cur_addr_reg    <= '0;
      len_reg         <= '0;
      remaining_reg   <= '0;
      issued_reg      <= '0;
      returned_reg    <= '0;
      outstanding_reg <= '0;
      rd_valid_reg    <= 1'b0;
      rd_last_reg     <= 1'b0;
      rd_data_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      cur_addr_reg    <= cur_addr_next;
      len_reg         <= len_next;
      remaining_reg   <= remaining_next;
      issued_reg      <= issued_next;
      returned_reg    <= returned_next;
      outstanding_reg <= outstanding_next;
      rd_valid_reg    <= rd_valid_next;
      rd_last_reg     <= rd_last_next;
      rd_data_reg     <= rd_data_next;
    end
  end

  assign busy         = (state_reg != S_IDLE);
  assign done         = (state_reg == S_DONE);
  assign wr_ready     = wr_fire;
  assign app_wdf_wren = wr_fire;
  assign app_wdf_end  = wr_fire;
  assign app_wdf_data = wr_data;
  assign app_wdf_mask = '0;
  assign app_addr     = cur_addr_reg;
  assign rd_valid     = rd_valid_reg;
  assign rd_last      = rd_last_reg;
  assign rd_data      = rd_data_reg;

endmodule

// File: tb/tb_mig_burst_engine.sv
// Scoreboard bench: stimulus pushes expected MIG commands and read beats into queues,
// a monitor that also models the MIG UI pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_mig_burst_engine;
  localparam int ADDR_W = 29, DATA_W = 32, ADDR_STEP = 8, LEN_W = 8, MAX_OUT = 4;

  logic ui_clk = 1'b0, ui_clk_sync_rst = 1'b1, init_calib_complete = 1'b0;
  logic start = 1'b0, op = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic busy, done, wr_ready, rd_valid, rd_last;
  logic [DATA_W-1:0] wr_data = '0, rd_data;
  logic wr_valid = 1'b0;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_wdf_wren, app_wdf_end;
  logic [DATA_W-1:0] app_wdf_data;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0;
  logic [DATA_W-1:0] app_rd_data = '0;

  mig_burst_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(ADDR_STEP),
                     .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst), .init_calib_complete(init_calib_complete),
    .start(start), .op(op), .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data));

  always #5 ui_clk = ~ui_clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [2:0] cmd; logic [DATA_W-1:0] data; } cmd_t;
  typedef struct { logic [DATA_W-1:0] data; logic last; } rd_t;
  cmd_t exp_cmd_q[$];
  rd_t  exp_rd_q[$];
  logic [DATA_W-1:0] wr_src[$];
  int due_q[$];
  logic [ADDR_W-1:0] ret_addr_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, lat = 4, rdy_mode = 0, wr_gap = 0, rdy_budget = -1;
  int acc_cnt = 0, outstanding = 0, max_out = 0;
  int last_acc_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic app_en_seen = 1'b0, done_prev = 1'b0, held_valid = 1'b0;
  logic [ADDR_W-1:0] held_addr = '0;

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    return {3'b101, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] b, input int n, input int tag);
    cmd_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = b + ADDR_W'(i * ADDR_STEP);
      e.cmd  = 3'b000;
      e.data = 32'hDA000000 + DATA_W'(tag * 256 + i);
      exp_cmd_q.push_back(e);
      wr_src.push_back(e.data);
    end
  endtask

  task automatic push_read(input logic [ADDR_W-1:0] b, input int n);
    cmd_t e;
    rd_t  r;
    for (int i = 0; i < n; i++) begin
      e.addr = b + ADDR_W'(i * ADDR_STEP);
      e.cmd  = 3'b001;
      e.data = '0;
      r.data = rd_word(e.addr);
      r.last = (i == n - 1);
      exp_cmd_q.push_back(e);
      exp_rd_q.push_back(r);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ui_clk);
    #1;
  endtask

  task automatic issue(input logic o, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    op = o; base_addr = b; len = l; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
    $display("txn %s finished at cycle %0d", name, cyc);
    tick(1);
  endtask

  // Write-data source: presents the head of wr_src, optionally with gaps.
  initial begin
    forever begin
      @(posedge ui_clk);
      #1;
      wr_valid = (wr_src.size() > 0) && (wr_gap == 0 || (cyc % 3) != 0);
      wr_data  = (wr_src.size() > 0) ? wr_src[0] : '0;
    end
  end

  // MIG model plus monitor: drive MIG inputs for the next edge, then observe what that edge will sample.
  initial begin
    cmd_t e;
    rd_t  r;
    forever begin
      @(negedge ui_clk);
      cyc++;
      if (ui_clk_sync_rst) begin
        due_q.delete();
        ret_addr_q.delete();
      end
      app_rd_data_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        app_rd_data = rd_word(ret_addr_q.pop_front());
        app_rd_data_valid = 1'b1;
      end
      app_rdy     = (rdy_budget != 0) && (rdy_mode == 0 || (cyc % 2) == 0);
      app_wdf_rdy = 1'b1;
      #1;
      if (!ui_clk_sync_rst) begin
        if (app_en && app_rdy) begin
          acc_cnt++;
          last_acc_cyc = cyc;
          if (rdy_budget > 0) rdy_budget--;
          if (exp_cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd: got addr %0h cmd %0d expected none", app_addr, app_cmd);
          end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_addr", 64'(app_addr), 64'(e.addr));
            check("cmd_op", 64'(app_cmd), 64'(e.cmd));
            if (e.cmd == 3'b000) begin
              check("wdf_data", 64'(app_wdf_data), 64'(e.data));
              check("wdf_wren_end", 64'({app_wdf_wren, app_wdf_end}), 64'd3);
              check("wdf_mask", 64'(app_wdf_mask), 64'd0);
            end else begin
              due_q.push_back(cyc + lat);
              ret_addr_q.push_back(app_addr);
              outstanding++;
              if (outstanding > max_out) max_out = outstanding;
              check("outstanding_le_max", 64'(outstanding <= MAX_OUT), 64'd1);
            end
          end
        end
        if (app_wdf_wren && !(app_en && app_rdy)) check("wren_without_cmd", 64'(app_wdf_wren), 64'd0);
        if (wr_valid && wr_ready) begin
          check("wr_ready_with_cmd", 64'(app_en && app_rdy), 64'd1);
          if (wr_src.size() > 0) void'(wr_src.pop_front());
        end
        if (app_en) app_en_seen = 1'b1;
        if (held_valid && app_en) check("addr_held", 64'(app_addr), 64'(held_addr));
        held_valid = app_en && !app_rdy;
        held_addr  = app_addr;
        if (app_rd_data_valid && outstanding > 0) outstanding--;
        if (rd_valid) begin
          if (exp_rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rd: got data %0h expected none", rd_data);
          end else begin
            r = exp_rd_q.pop_front();
            check("rd_data", 64'(rd_data), 64'(r.data));
            check("rd_last", 64'(rd_last), 64'(r.last));
          end
        end
        if (done) begin
          done_cyc = cyc;
          check("done_cmds_drained", 64'(exp_cmd_q.size()), 64'd0);
          check("done_rd_drained", 64'(exp_rd_q.size()), 64'd0);
        end
        if (done_prev) check("idle_after_done", 64'({busy, done}), 64'd0);
        done_prev = done;
        if (start && !busy && init_calib_complete) start_cyc = cyc;
      end
    end
  end

  initial begin
    int a0;
    init_calib_complete = 1'b1;
    tick(3);
    check("reset_outputs", 64'({busy, done, rd_valid, rd_last, app_en, app_wdf_wren}), 64'd0);
    ui_clk_sync_rst = 1'b0;
    tick(2);

    // 1: plain write burst
    push_write(29'h100, 4, 1);
    issue(1'b0, 29'h100, 8'd4);
    wait_done("write4", 50);
    check("write4_done_latency", 64'(done_cyc - last_acc_cyc), 64'd1);

    // 2: long-latency read against a 4-deep window, with a start ignored while busy
    lat = 20; max_out = 0;
    push_read(29'h2000, 10);
    issue(1'b1, 29'h2000, 8'd10);
    tick(3);
    op = 1'b0; base_addr = 29'h9000; len = 8'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("read10", 400);
    check("read10_max_outstanding", 64'(max_out), 64'd4);

    // 3: write with app_rdy toggling and wr_valid gaps
    rdy_mode = 1; wr_gap = 1;
    push_write(29'h400, 6, 3);
    issue(1'b0, 29'h400, 8'd6);
    wait_done("write6_stall", 200);
    rdy_mode = 0; wr_gap = 0;

    // 4: start without calibration, then a zero-length start
    init_calib_complete = 1'b0;
    issue(1'b0, 29'h40, 8'd3);
    tick(3);
    check("nocal_busy", 64'(busy), 64'd0);
    init_calib_complete = 1'b1;
    app_en_seen = 1'b0;
    issue(1'b0, 29'h80, 8'd0);
    check("len0_done", 64'(done), 64'd1);
    tick(2);
    check("len0_latency", 64'(done_cyc - start_cyc), 64'd1);
    check("len0_no_app_en", 64'(app_en_seen), 64'd0);

    // 5: address wrap
    lat = 4;
    push_read(29'h1FFFFFF8, 2);
    issue(1'b1, 29'h1FFFFFF8, 8'd2);
    wait_done("read_wrap", 50);

    // 6: reset mid-read after three accepted commands, then fresh operations
    a0 = acc_cnt;
    rdy_budget = 3;
    push_read(29'h3000, 8);
    issue(1'b1, 29'h3000, 8'd8);
    tick(12);
    check("midrd_accepts", 64'(acc_cnt - a0), 64'd3);
    check("midrd_busy_stalled", 64'({busy, app_en}), 64'd3);
    ui_clk_sync_rst = 1'b1;
    tick(1);
    check("midrd_reset_idle", 64'({busy, app_en, rd_valid, done}), 64'd0);
    ui_clk_sync_rst = 1'b0;
    exp_cmd_q.delete();
    exp_rd_q.delete();
    outstanding = 0;
    rdy_budget = -1;
    tick(1);
    push_read(29'h5000, 3);
    issue(1'b1, 29'h5000, 8'd3);
    wait_done("read_after_reset", 60);
    push_write(29'h6000, 2, 6);
    issue(1'b0, 29'h6000, 8'd2);
    wait_done("write_after_reset", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
